// File: rtl/ram_access_arbiter.sv
// Two-master (CPU / loader-DMA) arbiter in front of a single-port RAM.
// Same-cycle round-robin grant with a DMA starvation guard and an in-order read-return tag pipeline.
module ram_access_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              MAX10_CLK1_50,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_rden,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    logic              last_owner_q;
    logic              last_owner_d;
    logic [1:0]        dma_wait_q;
    logic [1:0]        dma_wait_d;
    logic [RD_LAT-1:0] tag_vld_q;
    logic [RD_LAT-1:0] tag_own_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;

    logic              cpu_gnt_s;
    logic              dma_gnt_s;
    logic              rd_gnt_s;
    logic              ret_vld_s;
    logic              ret_own_s;

    // Grant decision: reset blocks everything, the starvation guard beats round-robin.
    always_comb begin
        cpu_gnt_s = 1'b0;
        dma_gnt_s = 1'b0;
        if (reset) begin
            cpu_gnt_s = 1'b0;
            dma_gnt_s = 1'b0;
        end else if (cpu_req && dma_req) begin
            if ((dma_wait_q == 2'd3) || (last_owner_q == OWNER_CPU)) begin
                dma_gnt_s = 1'b1;
            end else begin
                cpu_gnt_s = 1'b1;
            end
        end else if (cpu_req) begin
            cpu_gnt_s = 1'b1;
        end else if (dma_req) begin
            dma_gnt_s = 1'b1;
        end else begin
            cpu_gnt_s = 1'b0;
            dma_gnt_s = 1'b0;
        end
    end

    // RAM port mux: an idle port still presents the CPU address/data.
    always_comb begin
        ram_address = cpu_addr;
        ram_data    = cpu_wdata;
        if (dma_gnt_s) begin
            ram_address = dma_addr;
            ram_data    = dma_wdata;
        end else begin
            ram_address = cpu_addr;
            ram_data    = cpu_wdata;
        end
    end

    assign ram_wren  = (cpu_gnt_s & cpu_we) | (dma_gnt_s & dma_we);
    assign ram_rden  = (cpu_gnt_s & ~cpu_we) | (dma_gnt_s & ~dma_we);
    assign rd_gnt_s  = ram_rden;
    assign cpu_gnt   = cpu_gnt_s;
    assign dma_gnt   = dma_gnt_s;
    assign cpu_stall = cpu_req & ~cpu_gnt_s;

    // Next-state for round-robin owner and the saturating DMA wait counter.
    always_comb begin
        last_owner_d = last_owner_q;
        dma_wait_d   = dma_wait_q;
        if (cpu_gnt_s) begin
            last_owner_d = OWNER_CPU;
        end else if (dma_gnt_s) begin
            last_owner_d = OWNER_DMA;
        end else begin
            last_owner_d = last_owner_q;
        end
        if (dma_gnt_s) begin
            dma_wait_d = 2'd0;
        end else if (dma_req && (dma_wait_q != 2'd3)) begin
            dma_wait_d = dma_wait_q + 2'd1;
        end else begin
            dma_wait_d = dma_wait_q;
        end
    end

    // Return steering; gating with reset kills any tag emerging during a reset cycle.
    assign ret_vld_s  = tag_vld_q[RD_LAT-1] & ~reset;
    assign ret_own_s  = tag_own_q[RD_LAT-1];
    assign cpu_rvalid = ret_vld_s & (ret_own_s == OWNER_CPU);
    assign dma_rvalid = ret_vld_s & (ret_own_s == OWNER_DMA);
    assign cpu_rdata  = cpu_rvalid ? ram_q : cpu_rdata_q;
    assign dma_rdata  = dma_rvalid ? ram_q : dma_rdata_q;

    // State registers: arbitration state, tag pipeline and last-delivered read data.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            last_owner_q <= OWNER_DMA;
            dma_wait_q   <= 2'd0;
            tag_vld_q    <= '0;
            tag_own_q    <= '0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            dma_wait_q   <= dma_wait_d;
            tag_vld_q[0] <= rd_gnt_s;
            tag_own_q[0] <= dma_gnt_s;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_own_q[i] <= tag_own_q[i-1];
            end
            if (cpu_rvalid) begin
                cpu_rdata_q <= ram_q;
            end
            if (dma_rvalid) begin
                dma_rdata_q <= ram_q;
            end
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench: one RD_LAT=1 and one RD_LAT=3 arbiter share stimulus, each with its own RAM model.
module tb_ram_access_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [4:0]  cpu_addr, dma_addr;
    logic [31:0] cpu_wdata, dma_wdata;
    logic        mem_init;

    logic        cpu_gnt1, cpu_stall1, cpu_rvalid1, dma_gnt1, dma_rvalid1, rden1, wren1;
    logic [31:0] cpu_rdata1, dma_rdata1, wdata1, q1;
    logic [4:0]  addr1;
    logic        cpu_gnt3, cpu_stall3, cpu_rvalid3, dma_gnt3, dma_rvalid3, rden3, wren3;
    logic [31:0] cpu_rdata3, dma_rdata3, wdata3, q3;
    logic [4:0]  addr3;

    logic [31:0] mem1 [0:31];
    logic [31:0] mem3 [0:31];
    logic [31:0] p3 [0:2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_access_arbiter #(.ADDR_W(5), .DATA_W(32), .RD_LAT(1)) u_dut1 (
        .MAX10_CLK1_50(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt1), .cpu_stall(cpu_stall1), .cpu_rvalid(cpu_rvalid1), .cpu_rdata(cpu_rdata1),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt1), .dma_rvalid(dma_rvalid1), .dma_rdata(dma_rdata1),
        .ram_address(addr1), .ram_data(wdata1), .ram_rden(rden1), .ram_wren(wren1), .ram_q(q1)
    );

    ram_access_arbiter #(.ADDR_W(5), .DATA_W(32), .RD_LAT(3)) u_dut3 (
        .MAX10_CLK1_50(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt3), .cpu_stall(cpu_stall3), .cpu_rvalid(cpu_rvalid3), .cpu_rdata(cpu_rdata3),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt3), .dma_rvalid(dma_rvalid3), .dma_rdata(dma_rdata3),
        .ram_address(addr3), .ram_data(wdata3), .ram_rden(rden3), .ram_wren(wren3), .ram_q(q3)
    );

    // RAM with one-cycle read latency
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem1[i] <= 32'hA000_0000 | i;
        end else if (wren1) begin
            mem1[addr1] <= wdata1;
        end
        if (rden1) q1 <= mem1[addr1];
    end

    // RAM with three-cycle read latency
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem3[i] <= 32'hA000_0000 | i;
        end else if (wren3) begin
            mem3[addr3] <= wdata3;
        end
        p3[0] <= rden3 ? mem3[addr3] : 32'h0000_0000;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign q3 = p3[2];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0; cpu_we = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
    endtask

    task automatic cpu_rd(input logic [4:0] a);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    endtask

    task automatic dma_rd(input logic [4:0] a);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = a;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_init = 1'b1;
        cpu_rd(5'd3); dma_rd(5'd7); cpu_wdata = 32'h0; dma_wdata = 32'h0;
        next_cycle();
        mem_init = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt1, dma_gnt1, rden1, wren1, cpu_rvalid1, dma_rvalid1} !== 6'b000000) begin
            n_fail++; $display("FAIL reset_outputs got %b want 000000", {cpu_gnt1, dma_gnt1, rden1, wren1, cpu_rvalid1, dma_rvalid1});
        end
        next_cycle();
        reset = 1'b0; idle();
        @(negedge clk);
        n_checks++;
        if (cpu_rdata1 !== 32'h0 || dma_rdata1 !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata got %h/%h want 0/0", cpu_rdata1, dma_rdata1);
        end
        n_checks++;
        if ({cpu_rvalid1, dma_rvalid1, rden1, wren1} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_idle got %b want 0000", {cpu_rvalid1, dma_rvalid1, rden1, wren1});
        end
    endtask

    task automatic test_contention();
        next_cycle();
        cpu_rd(5'd3); dma_rd(5'd7);
        @(negedge clk);
        n_checks++;
        if (cpu_gnt1 !== 1'b1 || dma_gnt1 !== 1'b0 || addr1 !== 5'd3 || rden1 !== 1'b1) begin
            n_fail++; $display("FAIL cont_c0 got gnt=%b%b addr=%0d rden=%b want 10 3 1", cpu_gnt1, dma_gnt1, addr1, rden1);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (dma_gnt1 !== 1'b1 || cpu_gnt1 !== 1'b0 || addr1 !== 5'd7) begin
            n_fail++; $display("FAIL cont_c1_gnt got gnt=%b%b addr=%0d want 01 7", cpu_gnt1, dma_gnt1, addr1);
        end
        n_checks++;
        if (cpu_rvalid1 !== 1'b1 || cpu_rdata1 !== 32'hA000_0003 || dma_rvalid1 !== 1'b0) begin
            n_fail++; $display("FAIL cont_c1_ret got v=%b d=%h dv=%b want 1 a0000003 0", cpu_rvalid1, cpu_rdata1, dma_rvalid1);
        end
        n_checks++;
        if (cpu_stall1 !== 1'b1) begin
            n_fail++; $display("FAIL stall_losing got %b want 1", cpu_stall1);
        end
        next_cycle();
        dma_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dma_rvalid1 !== 1'b1 || dma_rdata1 !== 32'hA000_0007 || cpu_rvalid1 !== 1'b0) begin
            n_fail++; $display("FAIL cont_c2_ret got dv=%b d=%h cv=%b want 1 a0000007 0", dma_rvalid1, dma_rdata1, cpu_rvalid1);
        end
        n_checks++;
        if (cpu_gnt1 !== 1'b1 || cpu_stall1 !== 1'b0) begin
            n_fail++; $display("FAIL stall_won got gnt=%b stall=%b want 1 0", cpu_gnt1, cpu_stall1);
        end
        next_cycle();
        idle(); cpu_addr = 5'd9; cpu_wdata = 32'h1234_5678;
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid1 !== 1'b1 || dma_rvalid1 !== 1'b0 || dma_rdata1 !== 32'hA000_0007) begin
            n_fail++; $display("FAIL cont_c3 got cv=%b dv=%b dd=%h want 1 0 a0000007", cpu_rvalid1, dma_rvalid1, dma_rdata1);
        end
        n_checks++;
        if (addr1 !== 5'd9 || wdata1 !== 32'h1234_5678 || rden1 !== 1'b0 || wren1 !== 1'b0) begin
            n_fail++; $display("FAIL idle_mux got a=%0d d=%h r=%b w=%b want 9 12345678 0 0", addr1, wdata1, rden1, wren1);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid1 !== 1'b0 || cpu_rdata1 !== 32'hA000_0003) begin
            n_fail++; $display("FAIL rdata_hold got v=%b d=%h want 0 a0000003", cpu_rvalid1, cpu_rdata1);
        end
    endtask

    task automatic test_dma_write();
        next_cycle();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 5'd5; dma_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if (dma_gnt1 !== 1'b1 || wren1 !== 1'b1 || rden1 !== 1'b0 || addr1 !== 5'd5 || wdata1 !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL dma_write got g=%b w=%b r=%b a=%0d d=%h want 1 1 0 5 deadbeef", dma_gnt1, wren1, rden1, addr1, wdata1);
        end
        next_cycle();
        idle(); cpu_rd(5'd5);
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid1 !== 1'b0 || dma_rvalid1 !== 1'b0 || cpu_gnt1 !== 1'b1) begin
            n_fail++; $display("FAIL write_no_rvalid got cv=%b dv=%b g=%b want 0 0 1", cpu_rvalid1, dma_rvalid1, cpu_gnt1);
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid1 !== 1'b1 || cpu_rdata1 !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL readback got v=%b d=%h want 1 deadbeef", cpu_rvalid1, cpu_rdata1);
        end
    endtask

    task automatic test_write_during_return();
        next_cycle();
        cpu_rd(5'd3);
        next_cycle();
        idle();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 5'd8; dma_wdata = 32'h0BAD_F00D;
        @(negedge clk);
        n_checks++;
        if (wren1 !== 1'b1 || dma_gnt1 !== 1'b1 || cpu_rvalid1 !== 1'b1 || cpu_rdata1 !== 32'hA000_0003) begin
            n_fail++; $display("FAIL write_vs_return got w=%b g=%b v=%b d=%h want 1 1 1 a0000003", wren1, dma_gnt1, cpu_rvalid1, cpu_rdata1);
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid1 !== 1'b0 || dma_rvalid1 !== 1'b0) begin
            n_fail++; $display("FAIL write_vs_return_after got %b%b want 00", cpu_rvalid1, dma_rvalid1);
        end
    endtask

    task automatic test_starvation();
        logic [3:0] exp_dma;
        exp_dma = 4'b1000;
        next_cycle();
        force u_dut1.last_owner_q = 1'b1;
        cpu_rd(5'd0); dma_rd(5'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (dma_gnt1 !== exp_dma[c] || cpu_gnt1 !== ~exp_dma[c] || cpu_stall1 !== exp_dma[c]) begin
                n_fail++; $display("FAIL starve_c%0d got dg=%b cg=%b st=%b want %b", c, dma_gnt1, cpu_gnt1, cpu_stall1, exp_dma[c]);
            end
            next_cycle();
        end
        idle();
        release u_dut1.last_owner_q;
        n_checks++;
        if (u_dut1.dma_wait_q !== 2'd0) begin
            n_fail++; $display("FAIL starve_wait_clear got %0d want 0", u_dut1.dma_wait_q);
        end
        for (int c = 0; c < 4; c++) next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  exp_cv, exp_dv;
        logic [31:0] exp_d [0:6];
        exp_cv = 4'b0101; exp_dv = 4'b1010;
        exp_d[3] = 32'hA000_0001; exp_d[4] = 32'hA000_0002;
        exp_d[5] = 32'hA000_0004; exp_d[6] = 32'hA000_0006;
        for (int c = 0; c < 7; c++) begin
            idle();
            case (c)
                0: cpu_rd(5'd1);
                1: dma_rd(5'd2);
                2: cpu_rd(5'd4);
                3: dma_rd(5'd6);
                default: idle();
            endcase
            @(negedge clk);
            if (c < 3) begin
                n_checks++;
                if (cpu_rvalid3 !== 1'b0 || dma_rvalid3 !== 1'b0) begin
                    n_fail++; $display("FAIL lat3_early_c%0d got %b%b want 00", c, cpu_rvalid3, dma_rvalid3);
                end
            end else begin
                n_checks++;
                if (cpu_rvalid3 !== exp_cv[c-3] || dma_rvalid3 !== exp_dv[c-3]) begin
                    n_fail++; $display("FAIL lat3_owner_c%0d got %b%b want %b%b", c, cpu_rvalid3, dma_rvalid3, exp_cv[c-3], exp_dv[c-3]);
                end
                n_checks++;
                if ((exp_cv[c-3] ? cpu_rdata3 : dma_rdata3) !== exp_d[c]) begin
                    n_fail++; $display("FAIL lat3_data_c%0d got %h want %h", c, exp_cv[c-3] ? cpu_rdata3 : dma_rdata3, exp_d[c]);
                end
            end
            next_cycle();
        end
        idle();
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid3 !== 1'b0 || dma_rvalid3 !== 1'b0 || cpu_rdata3 !== 32'hA000_0004) begin
            n_fail++; $display("FAIL lat3_drain got %b%b %h want 00 a0000004", cpu_rvalid3, dma_rvalid3, cpu_rdata3);
        end
    endtask

    task automatic test_reset_mid_read();
        next_cycle();
        cpu_rd(5'd3);
        next_cycle();
        reset = 1'b1; dma_rd(5'd7);
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt1, dma_gnt1, rden1, wren1, cpu_rvalid1, dma_rvalid1} !== 6'b000000) begin
            n_fail++; $display("FAIL midreset_outputs got %b want 000000", {cpu_gnt1, dma_gnt1, rden1, wren1, cpu_rvalid1, dma_rvalid1});
        end
        next_cycle();
        reset = 1'b0; idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (cpu_rvalid1 !== 1'b0 || cpu_rdata1 !== 32'h0 || cpu_rvalid3 !== 1'b0 || cpu_rdata3 !== 32'h0) begin
                n_fail++; $display("FAIL midreset_discard_c%0d got v1=%b d1=%h v3=%b d3=%h want 0 0 0 0", c, cpu_rvalid1, cpu_rdata1, cpu_rvalid3, cpu_rdata3);
            end
            next_cycle();
        end
    endtask

    initial begin
        cpu_addr = 5'd0; dma_addr = 5'd0; cpu_we = 1'b0; dma_we = 1'b0;
        test_reset();
        test_contention();
        test_dma_write();
        test_write_during_return();
        test_starvation();
        test_back_to_back();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_access_arbiter.md
RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_W, 5, RAM word-address width.
- DATA_W, 32, data width.
- RD_LAT, 1, RAM read latency in clocks, legal range 1..4.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- MAX10_CLK1_50, in, 1, sole clock; all state updates on its rising edge.
- reset, in, 1, synchronous active-high reset.
- cpu_req, in, 1, CPU data-port access request.
- cpu_we, in, 1, CPU request is a write.
- cpu_addr, in, ADDR_W, CPU word address.
- cpu_wdata, in, DATA_W, CPU write data.
- cpu_gnt, out, 1, CPU request accepted this cycle.
- cpu_stall, out, 1, equals cpu_req & ~cpu_gnt.
- cpu_rvalid, out, 1, CPU read data valid.
- cpu_rdata, out, DATA_W, CPU read data.
- dma_req, in, 1, loader/DMA request.
- dma_we, in, 1, loader/DMA request is a write.
- dma_addr, in, ADDR_W, loader/DMA word address.
- dma_wdata, in, DATA_W, loader/DMA write data.
- dma_gnt, out, 1, loader/DMA request accepted this cycle.
- dma_rvalid, out, 1, loader/DMA read data valid.
- dma_rdata, out, DATA_W, loader/DMA read data.
- ram_address, out, ADDR_W, address to the single-port RAM.
- ram_data, out, DATA_W, write data to the RAM.
- ram_rden, out, 1, RAM read enable.
- ram_wren, out, 1, RAM write enable.
- ram_q, in, DATA_W, RAM read data, valid RD_LAT cycles after ram_rden.

Function
REQ-003 Arbitration SHALL be combinational and same-cycle: at most one of cpu_gnt and dma_gnt is high; a grant is issued only to an asserted request.

REQ-004 Round-robin SHALL resolve contention:
- 1-bit register last_owner (0 = CPU, 1 = DMA).
- When both requests are high, grant goes to the requester that is not last_owner.
- last_owner updates to the granted requester on every grant.

REQ-005 With a single requester, it SHALL be granted that cycle regardless of last_owner.

REQ-006 Starvation guard:
- 2-bit counter dma_wait increments each cycle dma_req is high and dma_gnt is low; clears on dma_gnt.
- At dma_wait == 3, DMA SHALL be granted over CPU irrespective of last_owner.
- Saturates at 3.

REQ-007 The granted requester's signals SHALL drive the RAM in the grant cycle:
- ram_address = granted addr.
- ram_data = granted wdata.
- ram_wren = gnt & we.
- ram_rden = gnt & ~we.

REQ-008 With no grant, ram_rden and ram_wren SHALL be 0, and ram_address/ram_data SHALL hold CPU inputs.

REQ-009 Read-return tracking SHALL use a tag pipeline of depth RD_LAT:
- Each entry is {valid, owner}.
- Read grant inserts {1, owner}; every other cycle inserts {0, x}.
- The pipeline shifts every cycle.

REQ-010 When the pipeline output entry is valid, the owner's rvalid SHALL be 1 and its rdata = ram_q; the other rvalid is 0.

REQ-011 rdata of a non-valid port SHALL hold its last delivered value.

REQ-012 Reads SHALL be fully pipelined: back-to-back read grants in consecutive cycles, including alternating owners, each return in order exactly RD_LAT cycles later.

REQ-013 A write granted in the cycle a read return emerges SHALL NOT disturb that return.

REQ-014 Requesters hold req/we/addr/wdata stable until granted; a request dropped before grant is discarded with no side effect.

REQ-015 Writes SHALL produce no rvalid.

Reset
REQ-016 While reset is high at a clock edge, the block SHALL clear state:
- last_owner = 1 (CPU wins first contention).
- dma_wait = 0.
- All tag valids = 0.
- cpu_rdata = dma_rdata = 0.

REQ-017 During a reset cycle, cpu_gnt, dma_gnt, ram_rden, ram_wren, cpu_rvalid and dma_rvalid SHALL be 0 regardless of requests.

REQ-018 Reset mid-operation SHALL discard in-flight reads: no rvalid is produced for reads granted before reset.

Verification
REQ-019 Bench scenarios (RD_LAT = 1 unless stated):
- Contention after reset: cpu_req = dma_req = 1, cpu read addr 3, dma read addr 7 -> cycle 0 cpu_gnt, ram_address = 3; cycle 1 dma_gnt, ram_address = 7, cpu_rvalid with mem[3]; cycle 2 dma_rvalid with mem[7].
- Starvation guard: dma_req held high with round-robin overridden via continuous CPU grants (hold last_owner path) -> DMA granted no later than its 4th waiting cycle; dma_wait returns to 0.
- Lone DMA write: dma write addr 5 data 0xDEADBEEF with cpu idle -> same-cycle dma_gnt, ram_wren = 1, no rvalid; subsequent CPU read of 5 returns 0xDEADBEEF.
- RD_LAT = 3 pipelining: alternating CPU/DMA reads on 4 consecutive cycles -> rvalids appear cycles 3..6 in order with matching owners and data.
- Reset mid-read: CPU read granted, reset asserted next cycle -> no cpu_rvalid, cpu_rdata = 0, all grants low during reset.
- Stall: cpu_req high while DMA wins -> cpu_stall = 1 exactly for the losing cycles.
